// File: rtl/fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer, its synchronous program ROM and the decoder.
interface fetch_sequencer_if;
   logic        stall;
   logic [10:0] rom_addr;
   logic [13:0] rom_data;
   logic [13:0] instruction;
   logic [1:0]  codigo;
   logic        instr_valid;
   logic [10:0] exec_pc;
   logic        branch;
   logic [10:0] salto;
   logic        enablestak;
   logic        push;
   logic        pop;
   logic        skip;
   logic [3:0]  stack_depth;
   logic        stack_overflow;
   logic        stack_underflow;

   modport master (
      input  stall, rom_data, branch, salto, enablestak, push, pop, skip,
      output rom_addr, instruction, codigo, instr_valid, exec_pc,
             stack_depth, stack_overflow, stack_underflow
   );

   modport slave (
      output stall, rom_data, branch, salto, enablestak, push, pop, skip,
      input  rom_addr, instruction, codigo, instr_valid, exec_pc,
             stack_depth, stack_overflow, stack_underflow
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives a synchronous program ROM, presents one instruction per cycle and
// handles GOTO/CALL/RETURN through a circular return stack plus skip-next annulment.
module fetch_sequencer #(
   parameter int          STACK_DEPTH  = 8,
   parameter logic [10:0] RESET_VECTOR = 11'h000
) (
   input logic               clk,
   input logic               rst,
   fetch_sequencer_if.master bus
);
   localparam int         SPW  = $clog2(STACK_DEPTH);
   localparam logic [3:0] FULL = 4'(STACK_DEPTH);

   typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

   state_t         state, state_nxt;
   logic [10:0]    fetch_pc, exec_pc, fetch_pc_nxt, exec_pc_nxt;
   logic [10:0]    target, stack_top;
   logic [SPW-1:0] sp, sp_dec;
   logic [3:0]     depth;
   logic           overflow_q, underflow_q;
   logic [10:0]    stack_mem [STACK_DEPTH];
   logic           stalled_q;
   logic [13:0]    hold_q, word;
   logic           valid;
   logic           live, redirect, do_pop, do_push, do_skip;

   // Decoder controls only matter for a live, unstalled instruction.
   assign live      = (state == RUN) && !bus.stall;
   assign redirect  = live && bus.branch;
   assign do_pop    = redirect && bus.pop;
   assign do_push   = redirect && bus.push && bus.enablestak && !bus.pop;
   assign do_skip   = live && bus.skip && !bus.branch;
   assign sp_dec    = sp - SPW'(1);
   assign stack_top = stack_mem[sp_dec];
   assign target    = bus.pop ? stack_top : bus.salto;

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      if (rst)             state <= FILL;
      else if (!bus.stall) state <= state_nxt;
   end

   always_comb begin
      // NOTE: default assigned first so no path leaves state_nxt unassigned (no latch).
      state_nxt = state;
      case (state)
         FILL:    state_nxt = RUN;
         RUN:     if (redirect || do_skip) state_nxt = FLUSH;
         FLUSH:   state_nxt = RUN;
         default: state_nxt = FILL;
      endcase
   end

   always_comb begin
      valid           = (state == RUN);
      bus.instr_valid = valid;
      bus.instruction = valid ? word : 14'h0000;
      bus.codigo      = valid ? word[13:12] : 2'b00;
      bus.rom_addr    = fetch_pc;
      bus.exec_pc     = exec_pc;
      bus.stack_depth     = depth;
      bus.stack_overflow  = overflow_q;
      bus.stack_underflow = underflow_q;
   end

   // FILL and FLUSH simply advance; a redirect replaces the fetch address.
   always_comb begin
      fetch_pc_nxt = fetch_pc + 11'd1;
      exec_pc_nxt  = fetch_pc;
      if (redirect) begin
         fetch_pc_nxt = target;
         exec_pc_nxt  = exec_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc <= RESET_VECTOR;
         exec_pc  <= 11'h000;
      end else if (!bus.stall) begin
         fetch_pc <= fetch_pc_nxt;
         exec_pc  <= exec_pc_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sp          <= '0;
         depth       <= 4'd0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else if (do_pop) begin
         sp <= sp_dec;
         if (depth == 4'd0) underflow_q <= 1'b1;
         else               depth       <= depth - 4'd1;
      end else if (do_push) begin
         sp <= sp + SPW'(1);
         if (depth == FULL) overflow_q <= 1'b1;
         else               depth      <= depth + 4'd1;
      end
   end

   // NOTE: the return stack is plain storage with no reset; only sp/depth define its contents.
   always_ff @(posedge clk) begin
      if (!rst && do_push) stack_mem[sp] <= exec_pc + 11'd1;
   end

   // The ROM keeps reading while stalled, so the presented word is captured on stall entry.
   always_ff @(posedge clk) begin
      if (rst) stalled_q <= 1'b0;
      else     stalled_q <= bus.stall;
      if (!stalled_q) hold_q <= bus.rom_data;
   end

   assign word = stalled_q ? hold_q : bus.rom_data;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed scoreboard bench for fetch_sequencer: expected per-cycle outputs are queued when
// stimulus is driven and compared one cycle later against the DUT.
module tb_fetch_sequencer;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   fetch_sequencer_if bus ();

   fetch_sequencer #(.STACK_DEPTH(8), .RESET_VECTOR(11'h000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      string       tag;
      logic        valid;
      logic        pc_chk;
      logic [10:0] pc;
      logic [10:0] ra;
      logic [3:0]  depth;
      logic        ovf;
      logic        unf;
   } exp_t;

   exp_t        sb[$];
   int          tests = 0;
   int          fails = 0;
   logic [10:0] p;
   logic [3:0]  d;
   logic        ov, un;
   logic [10:0] rets [1:9];
   int          ord [9] = '{9, 8, 7, 6, 5, 4, 3, 2, 9};

   // Word N equals N below 0x200; upper addresses also set bits 13:12 so codigo is exercised.
   function automatic logic [13:0] rom_word(input logic [10:0] a);
      return {a[10:9], 1'b0, a};
   endfunction

   always @(posedge clk) bus.rom_data <= rom_word(bus.rom_addr);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic br, pu, po, en, sk, st, input logic [10:0] sa);
      bus.branch     = br;
      bus.push       = pu;
      bus.pop        = po;
      bus.enablestak = en;
      bus.skip       = sk;
      bus.stall      = st;
      bus.salto      = sa;
   endtask

   task automatic expect_cycle(input string tag, input logic v, input logic chk,
                               input logic [10:0] pc, input logic [10:0] ra);
      exp_t e;
      e.tag = tag; e.valid = v; e.pc_chk = chk; e.pc = pc; e.ra = ra;
      e.depth = d; e.ovf = ov; e.unf = un;
      sb.push_back(e);
   endtask

   task automatic advance();
      exp_t        e;
      logic [13:0] ins;
      @(posedge clk);
      #1;
      drive(0, 0, 0, 0, 0, 0, 11'h000);
      check("sb_level", sb.size(), 1);
      if (sb.size() > 0) begin
         e   = sb.pop_front();
         ins = e.valid ? rom_word(e.pc) : 14'h0000;
         check({e.tag, "/valid"}, bus.instr_valid, e.valid);
         check({e.tag, "/instr"}, bus.instruction, ins);
         check({e.tag, "/codigo"}, bus.codigo, ins[13:12]);
         check({e.tag, "/rom_addr"}, bus.rom_addr, e.ra);
         check({e.tag, "/depth"}, bus.stack_depth, e.depth);
         check({e.tag, "/ovf"}, bus.stack_overflow, e.ovf);
         check({e.tag, "/unf"}, bus.stack_underflow, e.unf);
         if (e.pc_chk) check({e.tag, "/exec_pc"}, bus.exec_pc, e.pc);
      end
   endtask

   task automatic t_seq(input string tag);
      expect_cycle(tag, 1, 1, p + 11'd1, p + 11'd2);
      p = p + 11'd1;
      advance();
   endtask

   // Redirect already driven by the caller: one annulled cycle, then land on tgt.
   task automatic t_jump(input string tag, input logic [10:0] tgt);
      expect_cycle({tag, "_flush"}, 0, 0, 11'h000, tgt);
      advance();
      expect_cycle({tag, "_land"}, 1, 1, tgt, tgt + 11'd1);
      p = tgt;
      advance();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 11'h000);
      repeat (2) @(posedge clk);
      #1;
      check("rst/valid", bus.instr_valid, 1'b0);
      check("rst/instr", bus.instruction, 14'h0000);
      check("rst/rom_addr", bus.rom_addr, 11'h000);
      check("rst/exec_pc", bus.exec_pc, 11'h000);
      check("rst/depth", bus.stack_depth, 4'd0);
      check("rst/ovf", bus.stack_overflow, 1'b0);
      check("rst/unf", bus.stack_underflow, 1'b0);
      rst = 1'b0;
      d = 4'd0; ov = 1'b0; un = 1'b0;

      expect_cycle("fill_exit", 1, 1, 11'h000, 11'h001);
      p = 11'h000;
      advance();
      for (int i = 0; i < 5; i++) t_seq("seq");

      drive(1, 1, 0, 0, 0, 0, 11'h100);
      t_jump("goto", 11'h100);
      t_seq("seq_100");

      drive(1, 1, 0, 0, 0, 0, 11'h7FE);
      t_jump("goto_7fe", 11'h7FE);
      t_seq("wrap");

      drive(1, 1, 0, 1, 0, 0, 11'h020);
      d = 4'd1;
      t_jump("call_7ff", 11'h020);
      drive(1, 1, 1, 1, 0, 0, 11'h3C3);
      d = 4'd0;
      t_jump("ret_000", 11'h000);

      for (int k = 1; k <= 9; k++) begin
         rets[k] = p + 11'd1;
         drive(1, 1, 0, 1, 0, 0, 11'h200 + 11'((k - 1) * 16));
         if (d < 4'd8) d = d + 4'd1;
         else          ov = 1'b1;
         t_jump("call_n", 11'h200 + 11'((k - 1) * 16));
      end
      for (int j = 0; j < 9; j++) begin
         drive(1, 0, 1, 0, 0, 0, 11'h000);
         if (d > 4'd0) d = d - 4'd1;
         else          un = 1'b1;
         t_jump("ret_n", rets[ord[j]]);
      end

      drive(1, 1, 0, 0, 0, 0, 11'h00A);
      t_jump("goto_a", 11'h00A);
      drive(0, 0, 0, 0, 1, 0, 11'h000);
      expect_cycle("skip_nop", 0, 1, 11'h00B, 11'h00C);
      advance();
      expect_cycle("skip_land", 1, 1, 11'h00C, 11'h00D);
      advance();
      p = 11'h00C;

      drive(1, 1, 0, 0, 1, 0, 11'h050);
      expect_cycle("skipbr_flush", 0, 0, 11'h000, 11'h050);
      advance();
      drive(1, 1, 0, 0, 0, 0, 11'h3FF);
      expect_cycle("flush_ignore", 1, 1, 11'h050, 11'h051);
      advance();
      p = 11'h050;
      t_seq("seq_51");

      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 0, 1, 0, 1, 11'h3AA);
         expect_cycle("stall", 1, 1, 11'h051, 11'h052);
         advance();
      end
      t_seq("unstall");

      drive(0, 0, 0, 0, 1, 0, 11'h000);
      expect_cycle("skip2_nop", 0, 1, 11'h053, 11'h054);
      advance();
      rst = 1'b1;
      d = 4'd0; ov = 1'b0; un = 1'b0;
      expect_cycle("rst_in_flush", 0, 1, 11'h000, 11'h000);
      advance();
      rst = 1'b0;
      expect_cycle("rst_exit", 1, 1, 11'h000, 11'h001);
      p = 11'h000;
      advance();
      t_seq("post_rst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
